// File: rtl/cg_sleep_ctrl.sv
// Core clock-gating sleep controller.
// Watches a WFI-style sleep request, waits for the core to be idle for IDLE_CYCLES
// consecutive cycles, then drops the clock-gate enable. Any interrupt or debug request
// brings the clock back, and the block signals completion after WAKE_CYCLES cycles of
// running clock.
// Optional feature: define CG_SLEEP_CTRL_STATS_EN to build the gated-cycle counter on
// sleep_cycles_o; otherwise that port reads 0 and stats_clr_i is ignored.
module cg_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sleep_req_i,
  input  logic        core_busy_i,
  input  logic        wake_i,
  input  logic        debug_req_i,
  input  logic        stats_clr_i,
  output logic        clk_en_o,
  output logic        sleeping_o,
  output logic        wake_done_o,
  output logic [31:0] sleep_cycles_o
);

  localparam logic [7:0] IdleLast = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WakeLast = 8'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDrain, StSleep, StWake} state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       clk_en_q;
  logic       wake_done_q;
  logic       wake_pend;

  assign wake_pend = wake_i | debug_req_i;

  // Sleep FSM; clk_en_q is updated on the same edge the state enters/leaves SLEEP so the
  // gate enable is a pure flop output that tracks the state exactly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      clk_en_q    <= 1'b1;
      wake_done_q <= 1'b0;
    end else begin
      wake_done_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (sleep_req_i && !wake_pend) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end
        end
        StDrain: begin
          // Losing the request or a pending wake beats any idle counting.
          if (wake_pend || !sleep_req_i) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else if (core_busy_i) begin
            cnt_q <= '0;
          end else if (cnt_q == IdleLast) begin
            state_q  <= StSleep;
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StSleep: begin
          if (wake_pend) begin
            state_q  <= StWake;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
          end
        end
        StWake: begin
          // Runs to completion even if the wake source goes away.
          if (cnt_q == WakeLast) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            wake_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign clk_en_o    = clk_en_q;
  assign sleeping_o  = ~clk_en_q;
  assign wake_done_o = wake_done_q;

`ifdef CG_SLEEP_CTRL_STATS_EN
  logic [31:0] sleep_cycles_q;

  // Saturating count of cycles spent gated; clear has priority over the increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sleep_cycles_q <= '0;
    end else if (stats_clr_i) begin
      sleep_cycles_q <= '0;
    end else if (state_q == StSleep && sleep_cycles_q != 32'hFFFF_FFFF) begin
      sleep_cycles_q <= sleep_cycles_q + 32'd1;
    end
  end

  assign sleep_cycles_o = sleep_cycles_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign sleep_cycles_o   = '0;
`endif

endmodule

// File: doc/cg_sleep_ctrl.md
CG_SLEEP_CTRL -- requirements
Module: cg_sleep_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 4, meaning consecutive idle cycles required before gating (1..255).
REQ-002 The block SHALL have parameter WAKE_CYCLES, default 2, meaning cycles the clock runs before wake is signalled complete (1..255).
REQ-003 The block SHALL have port clk_i, input, 1 bit: free-running (ungated) clock.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port sleep_req_i, input, 1 bit: core requests sleep (WFI), level.
REQ-006 The block SHALL have port core_busy_i, input, 1 bit: core has outstanding bus/pipeline activity.
REQ-007 The block SHALL have port wake_i, input, 1 bit: pending interrupt, level.
REQ-008 The block SHALL have port debug_req_i, input, 1 bit: debug request, level; treated as a wake source.
REQ-009 The block SHALL have port stats_clr_i, input, 1 bit: clears the sleep-cycle counter.
REQ-010 The block SHALL have port clk_en_o, output, 1 bit: enable to the core clock gate's en_i.
REQ-011 The block SHALL have port sleeping_o, output, 1 bit: high while the clock is gated.
REQ-012 The block SHALL have port wake_done_o, output, 1 bit: one-cycle pulse when the wake sequence completes.
REQ-013 The block SHALL have port sleep_cycles_o, output, 32 bits: count of gated cycles.

Function
REQ-014 The FSM SHALL have states RUN, DRAIN, SLEEP and WAKE, with an 8-bit counter cnt; wake_pend = wake_i | debug_req_i.
REQ-015 In RUN, sleep_req_i=1 and wake_pend=0 SHALL move the FSM to DRAIN with cnt=0; otherwise it stays in RUN.
REQ-016 In DRAIN, wake_pend=1 or sleep_req_i=0 SHALL return the FSM to RUN; this check has priority over all other DRAIN rules.
REQ-017 In DRAIN, core_busy_i=1 SHALL clear cnt to 0.
REQ-018 In DRAIN with core_busy_i=0, cnt SHALL increment, and the FSM SHALL move to SLEEP when cnt==IDLE_CYCLES-1.
REQ-019 With no interruptions, clk_en_o SHALL fall IDLE_CYCLES+1 cycles after sleep_req_i is first sampled high.
REQ-020 In SLEEP, wake_pend=1 SHALL move the FSM to WAKE with cnt=0; sleep_req_i and core_busy_i SHALL be ignored in SLEEP.
REQ-021 In WAKE, cnt SHALL increment, and the FSM SHALL move to RUN when cnt==WAKE_CYCLES-1.
REQ-022 Deassertion of wake_pend during WAKE SHALL NOT abort the wake.
REQ-023 wake_done_o SHALL be high exactly in the first RUN cycle after WAKE.
REQ-024 clk_en_o SHALL be 0 iff the state is SLEEP, driven from a register only (glitch-free, no combinational path from inputs).
REQ-025 sleeping_o SHALL equal ~clk_en_o.
REQ-026 sleep_cycles_o SHALL increment by 1 each cycle in SLEEP and saturate at 0xFFFFFFFF.
REQ-027 stats_clr_i SHALL set sleep_cycles_o to 0 and SHALL win over a simultaneous increment.

Reset
REQ-028 rst_ni=0 on a clk_i edge SHALL force state=RUN, cnt=0, clk_en_o=1, sleeping_o=0, wake_done_o=0, sleep_cycles_o=0.
REQ-029 Reset applied in SLEEP or DRAIN SHALL re-enable the clock on the next edge.

Configuration
REQ-030 Macro CG_SLEEP_CTRL_STATS_EN defined SHALL implement the sleep-cycle counter per REQ-026 and REQ-027.
REQ-031 Macro CG_SLEEP_CTRL_STATS_EN undefined SHALL tie sleep_cycles_o to 0, ignore stats_clr_i, and leave the port list unchanged.

Verification
REQ-032 Defaults, core_busy_i=0, sleep_req_i raised at cycle 0 and held -> clk_en_o=0 from cycle 5; sleeping_o=1.
REQ-033 In DRAIN with cnt=2, core_busy_i pulses high for 1 cycle -> cnt restarts; gating is delayed by 3 cycles versus REQ-032.
REQ-034 In SLEEP, wake_i pulsed for 1 cycle -> clk_en_o=1 on the next cycle; wake_done_o pulses 2 cycles later; FSM is in RUN.
REQ-035 wake_i high together with sleep_req_i in RUN -> FSM never leaves RUN; clk_en_o stays 1.
REQ-036 With the macro defined, sleep for 10 cycles, then stats_clr_i asserted during SLEEP -> sleep_cycles_o counts 10, then reads 0; with the macro undefined it reads 0 throughout.
REQ-037 rst_ni=0 for 1 cycle while in SLEEP -> clk_en_o=1 and state=RUN on the following cycle.
